// File: rtl/pe_load_sequencer_if.sv
// Bus bundle between pe_load_sequencer and its surroundings.
// Carries the weight and activation valid/ready streams, the PE load/compute
// port group and the valid/ready result port.
//   slave  : the sequencer's view (consumes streams, drives PE, offers result)
//   master : the environment's view (stream sources, PE, result sink)
interface pe_load_sequencer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WIDTH-1:0] a_data;
  logic                  a_valid;
  logic                  a_ready;
  logic [DATA_WIDTH-1:0] pe_filter_input;
  logic                  pe_load_enable_weight;
  logic [DATA_WIDTH-1:0] pe_activation_input;
  logic                  pe_load_enable_activation;
  logic                  pe_start;
  logic                  pe_load_done;
  logic                  pe_compute_done;
  logic [DATA_WIDTH-1:0] pe_out;
  logic [DATA_WIDTH-1:0] res_data;
  logic                  res_valid;
  logic                  res_ready;

  modport slave (
    input  w_data, w_valid,
    output w_ready,
    input  a_data, a_valid,
    output a_ready,
    output pe_filter_input, pe_load_enable_weight,
    output pe_activation_input, pe_load_enable_activation,
    output pe_start,
    input  pe_load_done, pe_compute_done, pe_out,
    output res_data, res_valid,
    input  res_ready
  );

  modport master (
    output w_data, w_valid,
    input  w_ready,
    output a_data, a_valid,
    input  a_ready,
    input  pe_filter_input, pe_load_enable_weight,
    input  pe_activation_input, pe_load_enable_activation,
    input  pe_start,
    output pe_load_done, pe_compute_done, pe_out,
    input  res_data, res_valid,
    output res_ready
  );
endinterface

// File: rtl/pe_load_sequencer.sv
// pe_load_sequencer: upstream feeder for one processing element.
// Pulls KERNEL_SIZE weights then ACTIVATION_SIZE activations from their
// valid/ready streams, strobes each word into the PE one cycle after its
// handshake, waits for pe_load_done, pulses pe_start, captures pe_out on
// pe_compute_done and offers it on the valid/ready result port.
// Ports:
//   clk    in   rising-edge clock
//   reset  in   asynchronous active-high reset (abandons any job in flight)
//   bus    slave modport of pe_load_sequencer_if (streams, PE, result)
//   busy   out  registered, high whenever the FSM is not idle
//   error  out  sticky watchdog flag
// Optional feature: define PE_SEQ_TIMEOUT_EN to enable a watchdog that
// aborts a job after TIMEOUT_CYCLES in WAIT_LOAD or WAIT_COMPUTE. Without
// it the FSM waits indefinitely and error is tied low.
module pe_load_sequencer #(
  parameter int DATA_WIDTH      = 16,
  parameter int KERNEL_SIZE     = 3,
  parameter int ACTIVATION_SIZE = 5,
  parameter int TIMEOUT_CYCLES  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  pe_load_sequencer_if.slave   bus,
  output logic                 busy,
  output logic                 error
);
  localparam int WCW = $clog2(KERNEL_SIZE + 1);
  localparam int ACW = $clog2(ACTIVATION_SIZE + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_W, LOAD_A, WAIT_LOAD, START, WAIT_COMPUTE, OUTPUT
  } state_t;

  state_t state, next_state;

  logic [WCW-1:0]        w_cnt;
  logic [ACW-1:0]        a_cnt;
  logic [DATA_WIDTH-1:0] filter_q, act_q, res_q;
  logic                  w_stb, a_stb, res_vld;
  logic                  w_fire, a_fire;
  logic                  timeout;

  assign w_fire = bus.w_valid && (state == LOAD_W);
  assign a_fire = bus.a_valid && (state == LOAD_A);

  assign bus.pe_filter_input           = filter_q;
  assign bus.pe_load_enable_weight     = w_stb;
  assign bus.pe_activation_input       = act_q;
  assign bus.pe_load_enable_activation = a_stb;
  assign bus.res_data                  = res_q;
  assign bus.res_valid                 = res_vld;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A completion arriving in the same cycle as the watchdog expiry wins.
  always_comb begin
    next_state  = state;
    bus.w_ready = 1'b0;
    bus.a_ready = 1'b0;
    bus.pe_start = 1'b0;
    case (state)
      IDLE:         if (bus.w_valid) next_state = LOAD_W;
      LOAD_W: begin
        bus.w_ready = 1'b1;
        if (w_fire && w_cnt == WCW'(KERNEL_SIZE - 1)) next_state = LOAD_A;
      end
      LOAD_A: begin
        bus.a_ready = 1'b1;
        if (a_fire && a_cnt == ACW'(ACTIVATION_SIZE - 1)) next_state = WAIT_LOAD;
      end
      WAIT_LOAD: begin
        if (bus.pe_load_done) next_state = START;
        else if (timeout)     next_state = IDLE;
      end
      START: begin
        bus.pe_start = 1'b1;
        next_state   = WAIT_COMPUTE;
      end
      WAIT_COMPUTE: begin
        if (bus.pe_compute_done) next_state = OUTPUT;
        else if (timeout)        next_state = IDLE;
      end
      OUTPUT:       if (bus.res_ready) next_state = IDLE;
      default:      next_state = IDLE;
    endcase
  end

  // Strobes are registered copies of the handshake, so each word reaches the
  // PE one cycle after it is accepted; data registers hold between strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_cnt    <= '0;
      a_cnt    <= '0;
      filter_q <= '0;
      act_q    <= '0;
      w_stb    <= 1'b0;
      a_stb    <= 1'b0;
      res_q    <= '0;
      res_vld  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      w_stb <= w_fire;
      a_stb <= a_fire;
      if (w_fire) filter_q <= bus.w_data;
      if (a_fire) act_q    <= bus.a_data;

      if (state != LOAD_W) w_cnt <= '0;
      else if (w_fire)     w_cnt <= w_cnt + 1'b1;
      if (state != LOAD_A) a_cnt <= '0;
      else if (a_fire)     a_cnt <= a_cnt + 1'b1;

      if (state == WAIT_COMPUTE && bus.pe_compute_done) begin
        res_q   <= bus.pe_out;
        res_vld <= 1'b1;
      end else if (state == OUTPUT && bus.res_ready) begin
        res_vld <= 1'b0;
      end

      busy <= (next_state != IDLE);
    end
  end

`ifdef PE_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] wait_cnt;
  logic          in_wait;

  assign in_wait = (state == WAIT_LOAD) || (state == WAIT_COMPUTE);
  assign timeout = in_wait && (wait_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Any state change clears the count, so it restarts on entry to either
  // wait state and measures only the time spent in the current one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
      error    <= 1'b0;
    end else begin
      if (next_state != state) wait_cnt <= '0;
      else if (in_wait)        wait_cnt <= wait_cnt + 1'b1;
      if (timeout && next_state == IDLE) error <= 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
  assign error   = 1'b0;
`endif

endmodule
